// File: rtl/div_sequencer.sv
// Control sequencer for the restoring shift-and-subtract divider bitslice array.
// Define DIV_SIGNED_EN to enable sign latching and operand/result negation.
module div_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic Op1Sign,
    input  logic Op2Sign,
    input  logic AccCout,
    input  logic DivZero,
    output logic Busy,
    output logic Done,
    output logic DivByZero,
    output logic LoadDivh,
    output logic LoadDivl,
    output logic LoadAcc,
    output logic LoadQuot,
    output logic LoadRem,
    output logic ShiftEn,
    output logic QuotBit,
    output logic InvOp1,
    output logic InvOp2,
    output logic InvRem,
    output logic InvResult,
    output logic Op1InvCin,
    output logic Op2InvCin,
    output logic ResultInvCin
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        SHIFT,
        SUB,
        FIX,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] count;
    logic          dbz_flag;
    logic          sign1;
    logic          sign2;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            count    <= '0;
            dbz_flag <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                LOAD: begin
                    count    <= '0;
                    dbz_flag <= 1'b0;
                end
                CHECK:   dbz_flag <= DivZero;
                SUB:     count    <= count + CW'(1);
                default: ;
            endcase
        end
    end

`ifdef DIV_SIGNED_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sign1 <= 1'b0;
            sign2 <= 1'b0;
        end else if (state == IDLE && Start) begin
            sign1 <= Op1Sign;
            sign2 <= Op2Sign;
        end
    end
`else
    // Unsigned-only build: sign inputs are deliberately left unconnected.
    logic unused_signs;
    assign unused_signs = Op1Sign ^ Op2Sign;
    assign sign1 = 1'b0;
    assign sign2 = 1'b0;
`endif

    always_comb begin
        next_state = state;
        Done       = 1'b0;
        DivByZero  = 1'b0;
        LoadDivh   = 1'b0;
        LoadDivl   = 1'b0;
        LoadAcc    = 1'b0;
        LoadQuot   = 1'b0;
        LoadRem    = 1'b0;
        ShiftEn    = 1'b0;
        QuotBit    = 1'b0;
        InvOp1     = 1'b0;
        InvOp2     = 1'b0;
        InvRem     = 1'b0;
        InvResult  = 1'b0;
        case (state)
            IDLE: begin
                if (Start) next_state = LOAD;
            end
            LOAD: begin
                LoadDivh   = 1'b1;
                LoadDivl   = 1'b1;
                LoadRem    = 1'b1;
                InvOp1     = sign1;
                InvOp2     = sign2;
                next_state = CHECK;
            end
            CHECK: begin
                next_state = DivZero ? DONE : SHIFT;
            end
            SHIFT: begin
                ShiftEn    = 1'b1;
                next_state = SUB;
            end
            SUB: begin
                // A negative trial difference restores by simply not loading the remainder.
                LoadAcc    = 1'b1;
                LoadQuot   = 1'b1;
                QuotBit    = AccCout;
                LoadRem    = AccCout;
                next_state = (count == CW'(WIDTH - 1)) ? FIX : SHIFT;
            end
            FIX: begin
                InvResult  = sign1 ^ sign2;
                InvRem     = sign1;
                LoadQuot   = 1'b1;
                LoadRem    = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                DivByZero  = dbz_flag;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign Busy         = (state != IDLE);
    assign Op1InvCin    = InvOp1;
    assign Op2InvCin    = InvOp2;
    assign ResultInvCin = InvResult;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer driving a small behavioural model of the
// bitslice datapath (divisor, dividend/quotient, remainder) from its control lines.
module tb_div_sequencer;

    logic Clock = 1'b0;
    logic Reset;
    logic Start;
    logic Op1Sign;
    logic Op2Sign;
    logic AccCout;
    logic DivZero;
    logic Busy, Done, DivByZero;
    logic LoadDivh, LoadDivl, LoadAcc, LoadQuot, LoadRem, ShiftEn, QuotBit;
    logic InvOp1, InvOp2, InvRem, InvResult, Op1InvCin, Op2InvCin, ResultInvCin;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] op1 = 8'd0;
    logic [7:0] op2 = 8'd0;
    logic [7:0] divh = 8'd0;
    logic [7:0] divl = 8'd0;
    logic [8:0] rem = 9'd0;
    logic [7:0] qlog = 8'd0;
    int shift_cnt = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int inv_cnt = 0;

    logic [16:0] outs;

    div_sequencer #(.WIDTH(8)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start(Start),
        .Op1Sign(Op1Sign),
        .Op2Sign(Op2Sign),
        .AccCout(AccCout),
        .DivZero(DivZero),
        .Busy(Busy),
        .Done(Done),
        .DivByZero(DivByZero),
        .LoadDivh(LoadDivh),
        .LoadDivl(LoadDivl),
        .LoadAcc(LoadAcc),
        .LoadQuot(LoadQuot),
        .LoadRem(LoadRem),
        .ShiftEn(ShiftEn),
        .QuotBit(QuotBit),
        .InvOp1(InvOp1),
        .InvOp2(InvOp2),
        .InvRem(InvRem),
        .InvResult(InvResult),
        .Op1InvCin(Op1InvCin),
        .Op2InvCin(Op2InvCin),
        .ResultInvCin(ResultInvCin)
    );

    always #5 Clock = ~Clock;

    assign outs = {Busy, Done, DivByZero, LoadDivh, LoadDivl, LoadAcc, LoadQuot, LoadRem,
                   ShiftEn, QuotBit, InvOp1, InvOp2, InvRem, InvResult,
                   Op1InvCin, Op2InvCin, ResultInvCin};

    // Datapath model: the trial difference is non-negative when remainder >= divisor.
    assign AccCout = (rem >= {1'b0, divh});
    assign DivZero = (divh == 8'd0);

    always @(posedge Clock) begin
        if (LoadDivh) divh <= InvOp2 ? -op2 : op2;
        if (LoadDivl) divl <= InvOp1 ? -op1 : op1;
        if (LoadRem && LoadDivh) begin
            rem <= 9'd0;
        end else if (ShiftEn) begin
            rem  <= {rem[7:0], divl[7]};
            divl <= {divl[6:0], 1'b0};
        end else if (LoadAcc) begin
            divl <= {divl[7:1], QuotBit};
            if (LoadRem) rem <= rem - {1'b0, divh};
            qlog <= {qlog[6:0], QuotBit};
        end else if (LoadQuot) begin
            divl <= InvResult ? -divl : divl;
            rem  <= InvRem ? -rem : rem;
        end
        if (ShiftEn) shift_cnt <= shift_cnt + 1;
        if (LoadAcc) acc_cnt <= acc_cnt + 1;
        if (Done) done_cnt <= done_cnt + 1;
        if (InvOp1 || InvOp2 || InvRem || InvResult || Op1InvCin || Op2InvCin || ResultInvCin)
            inv_cnt <= inv_cnt + 1;
    end

    task automatic advance_to(input int target);
        while (cyc < target) begin
            @(negedge Clock);
            cyc++;
        end
    endtask

    // Leaves the bench just after edge k; the next negedge is cycle k+1.
    task automatic start_div(input logic [7:0] a, input logic [7:0] b,
                             input logic s1, input logic s2);
        @(negedge Clock);
        op1     = a;
        op2     = b;
        Op1Sign = s1;
        Op2Sign = s2;
        Start   = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        Start = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        vectors++;
        if (outs !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: outs=%h expected %h", outs, 17'd0);
        end
        Reset = 1'b0;
        Start = 1'b0;
        @(negedge Clock);
        vectors++;
        if (outs !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: outs=%h expected %h", outs, 17'd0);
        end
    endtask

    task automatic test_unsigned;
        start_div(8'd100, 8'd7, 1'b0, 1'b0);
        advance_to(1);
        vectors++;
        if ({LoadDivh, LoadDivl, LoadRem, Busy} !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL load_cycle: got %b expected 1111", {LoadDivh, LoadDivl, LoadRem, Busy});
        end
        advance_to(19);
        vectors++;
        if (Done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL early_done: Done=%b expected 0", Done);
        end
        advance_to(20);
        vectors++;
        if ({Done, DivByZero} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL done_k20: Done,DivByZero=%b expected 10", {Done, DivByZero});
        end
        advance_to(21);
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL busy_k21: Busy=%b expected 0", Busy);
        end
        vectors++;
        if (divl !== 8'd14 || rem[7:0] !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL result_100_7: q=%0d r=%0d expected q=14 r=2", divl, rem[7:0]);
        end
        vectors++;
        if (qlog !== 8'b00001110) begin
            miscompares++;
            $display("[TB] FAIL quotbit_seq: got %b expected 00001110", qlog);
        end
    endtask

    task automatic test_div_zero;
        int shifts0;
        int accs0;
        shifts0 = shift_cnt;
        accs0   = acc_cnt;
        start_div(8'd50, 8'd0, 1'b0, 1'b0);
        advance_to(2);
        vectors++;
        if (Done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dbz_early: Done=%b expected 0", Done);
        end
        advance_to(3);
        vectors++;
        if ({Done, DivByZero} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL dbz_done_k3: Done,DivByZero=%b expected 11", {Done, DivByZero});
        end
        advance_to(4);
        vectors++;
        if (outs !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL dbz_idle: outs=%h expected 0", outs);
        end
        vectors++;
        if (shift_cnt != shifts0 || acc_cnt != accs0) begin
            miscompares++;
            $display("[TB] FAIL dbz_no_iter: shifts=%0d accs=%0d expected 0 0",
                     shift_cnt - shifts0, acc_cnt - accs0);
        end
    endtask

    task automatic test_ignored_start;
        int dones0;
        dones0 = done_cnt;
        start_div(8'd100, 8'd7, 1'b0, 1'b0);
        advance_to(5);
        Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        advance_to(20);
        vectors++;
        if (Done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ign_done_k20: Done=%b expected 1", Done);
        end
        Start = 1'b1;
        advance_to(21);
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ign_busy_k21: Busy=%b expected 0", Busy);
        end
        Start = 1'b0;
        advance_to(22);
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ign_not_queued: Busy=%b expected 0", Busy);
        end
        vectors++;
        if (done_cnt - dones0 != 1 || divl !== 8'd14) begin
            miscompares++;
            $display("[TB] FAIL ign_single_done: dones=%0d q=%0d expected 1 14", done_cnt - dones0, divl);
        end
    endtask

    task automatic test_mid_reset;
        start_div(8'd100, 8'd7, 1'b0, 1'b0);
        advance_to(10);
        vectors++;
        if (LoadAcc !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_in_sub: LoadAcc=%b expected 1", LoadAcc);
        end
        Reset = 1'b1;
        advance_to(11);
        vectors++;
        if (outs !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_idle: outs=%h expected 0", outs);
        end
        Reset = 1'b0;
        start_div(8'd100, 8'd7, 1'b0, 1'b0);
        advance_to(19);
        vectors++;
        if (Done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_early: Done=%b expected 0", Done);
        end
        advance_to(20);
        vectors++;
        if (Done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_done: Done=%b expected 1", Done);
        end
        advance_to(21);
        vectors++;
        if (divl !== 8'd14 || rem[7:0] !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL midrst_result: q=%0d r=%0d expected 14 2", divl, rem[7:0]);
        end
    endtask

    task automatic test_signed;
`ifdef DIV_SIGNED_EN
        start_div(8'd156, 8'd7, 1'b1, 1'b0);
        advance_to(1);
        vectors++;
        if ({InvOp1, Op1InvCin, InvOp2, Op2InvCin} !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL signed_load: got %b expected 1100", {InvOp1, Op1InvCin, InvOp2, Op2InvCin});
        end
        advance_to(19);
        vectors++;
        if ({InvResult, ResultInvCin, InvRem} !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL signed_fix: got %b expected 111", {InvResult, ResultInvCin, InvRem});
        end
        advance_to(21);
        vectors++;
        if (divl !== 8'd242 || rem[7:0] !== 8'd254) begin
            miscompares++;
            $display("[TB] FAIL signed_result: q=%0d r=%0d expected 242 254", divl, rem[7:0]);
        end
`else
        int invs0;
        invs0 = inv_cnt;
        start_div(8'd156, 8'd7, 1'b1, 1'b1);
        advance_to(21);
        vectors++;
        if (inv_cnt != invs0) begin
            miscompares++;
            $display("[TB] FAIL unsigned_inv: inv cycles=%0d expected 0", inv_cnt - invs0);
        end
        vectors++;
        if (divl !== 8'd22 || rem[7:0] !== 8'd2) begin
            miscompares++;
            $display("[TB] FAIL unsigned_156_7: q=%0d r=%0d expected 22 2", divl, rem[7:0]);
        end
`endif
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b0;
        Op1Sign = 1'b0;
        Op2Sign = 1'b0;
        test_reset;
        test_unsigned;
        test_div_zero;
        test_ignored_start;
        test_mid_reset;
        test_signed;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
